// File: rtl/sram_ctr_ahb_param.sv
// AHB-Lite slave in front of one single-port synchronous SRAM macro.
// It supports byte, halfword and word writes, adds read wait states and returns the two-cycle ERROR response for illegal transfers.
//
// state      | meaning
// -----------+----------------------------------------------------
// S_IDLE     | no data phase in flight, ready for an address phase
// S_WR       | write data phase, SRAM write strobe active
// S_RD_ISSUE | read strobe to SRAM, bus stalled
// S_RD_WAIT  | waiting out the SRAM read latency
// S_RD_DONE  | read data on hrdata, bus ready
// S_ERR1     | first ERROR cycle (hready low)
// S_ERR2     | second ERROR cycle (hready high)
module sram_ctr_ahb_param #(
  parameter int SRAM_AW     = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               hsel,
  input  logic               hwrite,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hsize,
  input  logic [31:0]        haddr,
  input  logic [2:0]         hburst,
  input  logic [31:0]        hwdata,
  output logic               hready,
  output logic [1:0]         hresp,
  output logic [31:0]        hrdata,
  output logic               sram_csn,
  output logic               sram_wen,
  output logic [3:0]         sram_be,
  output logic [SRAM_AW-1:0] sram_a,
  output logic [31:0]        sram_d,
  input  logic [31:0]        sram_q
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_ISSUE, S_RD_WAIT, S_RD_DONE, S_ERR1, S_ERR2
  } state_t;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [3:0] WAIT_LOAD   = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t             r_state;
  logic               r_hready;
  logic [1:0]         r_hresp;
  logic               r_csn;
  logic               r_wen;
  logic [3:0]         r_be;
  logic [SRAM_AW-1:0] r_a;
  logic [3:0]         r_wait_cnt;

  logic       w_accept;
  logic       w_err;
  logic [3:0] w_be;
  logic       w_unused;

  assign w_accept = r_hready & hsel & htrans[1];
  assign w_err    = (hsize > 3'b010)
                  | ((hsize == 3'b001) & haddr[0])
                  | ((hsize == 3'b010) & (haddr[1:0] != 2'b00))
                  | ((haddr >> (SRAM_AW + 2)) != 32'd0);

  always_comb begin
    w_be = 4'b1111;
    case (hsize)
      3'b000:  w_be = 4'b0001 << haddr[1:0];
      3'b001:  w_be = haddr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Strobes default to inactive every cycle, so they last one cycle and nothing stays pending after an abort.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state    <= S_IDLE;
      r_hready   <= 1'b1;
      r_hresp    <= HRESP_OKAY;
      r_csn      <= 1'b1;
      r_wen      <= 1'b1;
      r_be       <= 4'b0000;
      r_a        <= '0;
      r_wait_cnt <= 4'd0;
    end else begin
      r_csn <= 1'b1;
      r_wen <= 1'b1;
      r_be  <= 4'b0000;
      case (r_state)
        S_RD_ISSUE: begin
          if (WAIT_STATES > 0) begin
            r_state    <= S_RD_WAIT;
            r_wait_cnt <= WAIT_LOAD;
          end else begin
            r_state  <= S_RD_DONE;
            r_hready <= 1'b1;
          end
        end
        S_RD_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_state  <= S_RD_DONE;
            r_hready <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          r_state  <= S_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_ERROR;
        end
        default: begin
          r_state  <= S_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_OKAY;
          if (w_accept) begin
            if (w_err) begin
              r_state  <= S_ERR1;
              r_hready <= 1'b0;
              r_hresp  <= HRESP_ERROR;
            end else if (hwrite) begin
              r_state <= S_WR;
              r_csn   <= 1'b0;
              r_wen   <= 1'b0;
              r_be    <= w_be;
              r_a     <= haddr[SRAM_AW+1:2];
            end else begin
              r_state  <= S_RD_ISSUE;
              r_hready <= 1'b0;
              r_csn    <= 1'b0;
              r_a      <= haddr[SRAM_AW+1:2];
            end
          end
        end
      endcase
    end
  end

  // The SRAM data arrives only during RD_DONE, so hrdata cannot be registered.
  assign hrdata   = (r_state == S_RD_DONE) ? sram_q : 32'd0;
  assign hready   = r_hready;
  assign hresp    = r_hresp;
  assign sram_csn = r_csn;
  assign sram_wen = r_wen;
  assign sram_be  = r_be;
  assign sram_a   = r_a;
  assign sram_d   = hwdata;

  // hburst is informational only, and BUSY is treated the same as IDLE.
  assign w_unused = ^{hburst, htrans[0]};

endmodule

// File: tb/tb_sram_ctr_ahb_param.sv
// Bench for sram_ctr_ahb_param: two slaves (0 and 3 wait states) share one AHB bus and each drives its own SRAM model.
// The driver queues the expected responses, and a negedge monitor checks each data phase as it completes.
module tb_sram_ctr_ahb_param;
  localparam int AW = 12;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010;

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [11:0] a;
    int          waits;
  } exp_t;

  logic hclk = 1'b0, hresetn = 1'b0;
  logic hsel0 = 1'b0, hsel1 = 1'b0, hwrite = 1'b0;
  logic [1:0] htrans = IDLE;
  logic [2:0] hsize = SZ_W, hburst = 3'b000;
  logic [31:0] haddr = 32'd0, hwdata = 32'd0;

  logic hready0, hready1, csn0, csn1, wen0, wen1;
  logic [1:0] hresp0, hresp1;
  logic [31:0] hrdata0, hrdata1, d0, d1;
  logic [31:0] q0 = 32'd0, q1 = 32'd0;
  logic [3:0] be0, be1;
  logic [AW-1:0] a0, a1;
  logic [31:0] mem0 [1<<AW];
  logic [31:0] mem1 [1<<AW];

  bit cur_sel = 1'b0;
  int checks = 0, errors = 0;
  exp_t q_exp[$];
  logic [31:0] pend_wd = 32'd0;
  bit in_data = 1'b0;

  always #5 hclk = ~hclk;

  sram_ctr_ahb_param #(.SRAM_AW(AW), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .haddr(haddr), .hburst(hburst), .hwdata(hwdata),
    .hready(hready0), .hresp(hresp0), .hrdata(hrdata0), .sram_csn(csn0), .sram_wen(wen0),
    .sram_be(be0), .sram_a(a0), .sram_d(d0), .sram_q(q0));

  sram_ctr_ahb_param #(.SRAM_AW(AW), .WAIT_STATES(3)) dut1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .haddr(haddr), .hburst(hburst), .hwdata(hwdata),
    .hready(hready1), .hresp(hresp1), .hrdata(hrdata1), .sram_csn(csn1), .sram_wen(wen1),
    .sram_be(be1), .sram_a(a1), .sram_d(d1), .sram_q(q1));

  // SRAM models: one-cycle read latency, q holds between accesses
  always @(posedge hclk) begin
    if (!csn0) begin
      if (!wen0) begin
        for (int i = 0; i < 4; i++) if (be0[i]) mem0[a0][8*i +: 8] <= d0[8*i +: 8];
      end else q0 <= mem0[a0];
    end
  end
  always @(posedge hclk) begin
    if (!csn1) begin
      if (!wen1) begin
        for (int i = 0; i < 4; i++) if (be1[i]) mem1[a1][8*i +: 8] <= d1[8*i +: 8];
      end else q1 <= mem1[a1];
    end
  end

  logic m_hready, m_hsel, m_csn, m_wen, o_csn, o_hready;
  logic [1:0] m_hresp;
  logic [31:0] m_hrdata;
  logic [3:0] m_be;
  logic [AW-1:0] m_a;
  assign m_hready = cur_sel ? hready1 : hready0;
  assign m_hsel   = cur_sel ? hsel1 : hsel0;
  assign m_csn    = cur_sel ? csn1 : csn0;
  assign m_wen    = cur_sel ? wen1 : wen0;
  assign m_hresp  = cur_sel ? hresp1 : hresp0;
  assign m_hrdata = cur_sel ? hrdata1 : hrdata0;
  assign m_be     = cur_sel ? be1 : be0;
  assign m_a      = cur_sel ? a1 : a0;
  assign o_csn    = cur_sel ? csn0 : csn1;
  assign o_hready = cur_sel ? hready0 : hready1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: one pass per negedge
  initial begin
    int k = 0;
    logic [31:0] mask = 0;
    logic [1:0] resp_first = 0;
    logic wen_first = 1;
    logic [3:0] be_first = 0;
    logic [AW-1:0] a_first = 0;
    exp_t e;
    forever begin
      @(negedge hclk);
      if (!hresetn) begin
        if (in_data && q_exp.size() > 0) e = q_exp.pop_front();
        in_data = 1'b0;
      end else begin
        if (in_data) begin
          if (k == 0) begin
            resp_first = m_hresp; wen_first = m_wen; be_first = m_be; a_first = m_a;
          end
          if (!m_csn && k < 32) mask[k] = 1'b1;
          if (!m_hready) k++;
          else begin
            in_data = 1'b0;
            if (q_exp.size() == 0) chk("unexpected_data_phase", 32'd1, 32'd0);
            else begin
              e = q_exp.pop_front();
              chk($sformatf("waits@%h", e.addr), 32'(k), 32'(e.waits));
              chk($sformatf("hresp@%h", e.addr), 32'(m_hresp), e.err ? 32'd1 : 32'd0);
              chk($sformatf("hresp_first@%h", e.addr), 32'(resp_first), e.err ? 32'd1 : 32'd0);
              chk($sformatf("csn_pattern@%h", e.addr), mask, e.err ? 32'd0 : 32'd1);
              chk($sformatf("hrdata@%h", e.addr), m_hrdata, e.rdata);
              chk($sformatf("be@%h", e.addr), 32'(be_first), 32'(e.be));
              if (!e.err) begin
                chk($sformatf("wen@%h", e.addr), 32'(wen_first), e.rd ? 32'd1 : 32'd0);
                chk($sformatf("sram_a@%h", e.addr), 32'(a_first), 32'(e.a));
              end
            end
          end
        end else begin
          chk("stray_csn", 32'(m_csn), 32'd1);
        end
        chk("unselected_csn", 32'(o_csn), 32'd1);
        chk("unselected_hready", 32'(o_hready), 32'd1);
        if (m_hready && m_hsel && htrans[1]) begin
          in_data = 1'b1; k = 0; mask = 0;
        end
      end
    end
  end

  // Issues one address phase (and the previous transfer's write data); returns just after it is accepted.
  task automatic xfer(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] ad, input logic [31:0] wd, input logic er,
                      input logic [31:0] rd_exp, input logic [3:0] be_exp);
    exp_t e;
    int n = 0;
    hsel0  = (cur_sel == 1'b0) && (tr != IDLE);
    hsel1  = (cur_sel == 1'b1) && (tr != IDLE);
    htrans = tr; hwrite = wr; hsize = sz; haddr = ad;
    hwdata = pend_wd;
    pend_wd = (tr[1] && wr) ? wd : 32'd0;
    if (tr[1]) begin
      e.rd = !wr; e.err = er; e.addr = ad;
      e.rdata = (!wr && !er) ? rd_exp : 32'd0;
      e.be = (wr && !er) ? be_exp : 4'b0000;
      e.a = ad[13:2];
      e.waits = er ? 1 : (wr ? 0 : (cur_sel ? 4 : 1));
      q_exp.push_back(e);
    end
    @(negedge hclk);
    while (!m_hready && n < 40) begin n++; @(negedge hclk); end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL hready_timeout@%h: hready still 0 after %0d cycles, required 1", ad, n);
    end
    @(posedge hclk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) xfer(IDLE, 1'b0, SZ_W, 32'd0, 32'd0, 1'b0, 32'd0, 4'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge hclk);
    #1;
    chk("rst_hready0", 32'(hready0), 32'd1);
    chk("rst_hresp0", 32'(hresp0), 32'd0);
    chk("rst_hrdata0", hrdata0, 32'd0);
    chk("rst_csn0", 32'(csn0), 32'd1);
    chk("rst_wen0", 32'(wen0), 32'd1);
    chk("rst_be0", 32'(be0), 32'd0);
    chk("rst_a0", 32'(a0), 32'd0);
    chk("rst_hready1", 32'(hready1), 32'd1);
    chk("rst_csn1", 32'(csn1), 32'd1);
    hresetn = 1'b1;
    @(posedge hclk); #1;

    // slave 0, no wait states
    cur_sel = 1'b0;
    xfer(NSEQ, 1, SZ_W, 32'h10, 32'hDEADBEEF, 0, 0, 4'b1111);
    xfer(NSEQ, 0, SZ_W, 32'h10, 0, 0, 32'hDEADBEEF, 0);
    xfer(NSEQ, 1, SZ_B, 32'h13, 32'hAA000000, 0, 0, 4'b1000);
    xfer(NSEQ, 1, SZ_H, 32'h14, 32'h00005555, 0, 0, 4'b0011);
    xfer(NSEQ, 1, SZ_B, 32'h11, 32'h00001100, 0, 0, 4'b0010);
    xfer(NSEQ, 1, SZ_H, 32'h16, 32'h77770000, 0, 0, 4'b1100);
    xfer(NSEQ, 0, SZ_W, 32'h10, 0, 0, 32'hAAAD11EF, 0);
    xfer(NSEQ, 0, SZ_W, 32'h14, 0, 0, 32'h77775555, 0);
    idle(1);
    // illegal transfers, then the last legal word
    xfer(NSEQ, 0, SZ_H, 32'h01, 0, 1, 0, 0);
    xfer(NSEQ, 1, SZ_W, 32'h4002, 32'h12121212, 1, 0, 0);
    xfer(NSEQ, 0, 3'b011, 32'h0, 0, 1, 0, 0);
    xfer(NSEQ, 0, SZ_W, 32'h4000, 0, 1, 0, 0);
    xfer(NSEQ, 1, SZ_W, 32'h3FFC, 32'hCAFEF00D, 0, 0, 4'b1111);
    xfer(NSEQ, 0, SZ_W, 32'h3FFC, 0, 0, 32'hCAFEF00D, 0);
    idle(1);
    // INCR4 writes and reads with a BUSY in the middle
    hburst = 3'b011;
    xfer(NSEQ, 1, SZ_W, 32'h40, 32'h11111111, 0, 0, 4'b1111);
    xfer(SEQ,  1, SZ_W, 32'h44, 32'h22222222, 0, 0, 4'b1111);
    xfer(BUSY, 1, SZ_W, 32'h48, 0, 0, 0, 0);
    xfer(SEQ,  1, SZ_W, 32'h48, 32'h33333333, 0, 0, 4'b1111);
    xfer(SEQ,  1, SZ_W, 32'h4C, 32'h44444444, 0, 0, 4'b1111);
    xfer(NSEQ, 0, SZ_W, 32'h40, 0, 0, 32'h11111111, 0);
    xfer(SEQ,  0, SZ_W, 32'h44, 0, 0, 32'h22222222, 0);
    xfer(BUSY, 0, SZ_W, 32'h48, 0, 0, 0, 0);
    xfer(SEQ,  0, SZ_W, 32'h48, 0, 0, 32'h33333333, 0);
    xfer(SEQ,  0, SZ_W, 32'h4C, 0, 0, 32'h44444444, 0);
    hburst = 3'b000;
    idle(2);

    // slave 1, three wait states
    cur_sel = 1'b1;
    xfer(NSEQ, 1, SZ_W, 32'h20, 32'h12345678, 0, 0, 4'b1111);
    xfer(NSEQ, 0, SZ_W, 32'h20, 0, 0, 32'h12345678, 0);
    xfer(NSEQ, 1, 3'b100, 32'h0, 32'h0, 1, 0, 0);
    hburst = 3'b011;
    xfer(NSEQ, 1, SZ_W, 32'h40, 32'hA0A0A0A0, 0, 0, 4'b1111);
    xfer(SEQ,  1, SZ_W, 32'h44, 32'hB1B1B1B1, 0, 0, 4'b1111);
    xfer(SEQ,  1, SZ_W, 32'h48, 32'hC2C2C2C2, 0, 0, 4'b1111);
    xfer(SEQ,  1, SZ_W, 32'h4C, 32'hD3D3D3D3, 0, 0, 4'b1111);
    xfer(NSEQ, 0, SZ_W, 32'h40, 0, 0, 32'hA0A0A0A0, 0);
    xfer(SEQ,  0, SZ_W, 32'h44, 0, 0, 32'hB1B1B1B1, 0);
    xfer(BUSY, 0, SZ_W, 32'h48, 0, 0, 0, 0);
    xfer(SEQ,  0, SZ_W, 32'h48, 0, 0, 32'hC2C2C2C2, 0);
    xfer(SEQ,  0, SZ_W, 32'h4C, 0, 0, 32'hD3D3D3D3, 0);
    hburst = 3'b000;
    idle(2);

    // reset during RD_WAIT aborts the read
    xfer(NSEQ, 0, SZ_W, 32'h20, 0, 0, 32'h12345678, 0);
    hsel1 = 1'b0; htrans = IDLE; hwdata = 32'd0;
    @(posedge hclk); #1;
    chk("stalled_before_reset", 32'(hready1), 32'd0);
    hresetn = 1'b0;
    @(posedge hclk); #1;
    chk("reset_hready", 32'(hready1), 32'd1);
    chk("reset_hresp", 32'(hresp1), 32'd0);
    chk("reset_csn", 32'(csn1), 32'd1);
    chk("reset_hrdata", hrdata1, 32'd0);
    hresetn = 1'b1;
    pend_wd = 32'd0;
    @(posedge hclk); #1;
    xfer(NSEQ, 1, SZ_W, 32'h24, 32'h0BADF00D, 0, 0, 4'b1111);
    xfer(NSEQ, 0, SZ_W, 32'h24, 0, 0, 32'h0BADF00D, 0);
    xfer(NSEQ, 0, SZ_W, 32'h20, 0, 0, 32'h12345678, 0);
    idle(3);

    chk("scoreboard_empty", 32'(q_exp.size()), 32'd0);
    chk("no_open_data_phase", 32'(in_data), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_ctr_ahb_param.md
Name: sram_ctr_ahb_param

Overview:
Parametrised AHB-Lite slave bridging the AHB bus to a single-port synchronous SRAM.
- SRAM depth, read wait states and byte-lane writes are configurable.
- Supports byte, halfword and word writes through byte enables.
- Validates every transfer and answers illegal ones with the AHB two-cycle ERROR response.
- Sits between the AHB interconnect and one SRAM macro; pin-compatible on the AHB side with the existing SRAM controller plus hsel.

Parameters:
SRAM_AW, 12, SRAM word-address width; slave covers 4*2**SRAM_AW bytes from offset 0.
WAIT_STATES, 0, extra read cycles needed by the SRAM macro (legal range 0..15).

Ports:
hclk  in  1  bus clock, all logic on rising edge.
hresetn  in  1  synchronous active-low reset.
hsel  in  1  slave select.
hwrite  in  1  1=write, 0=read.
htrans  in  2  IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
hsize  in  3  transfer size.
haddr  in  32  byte address.
hburst  in  3  burst type; informational only, no address generation from it.
hwdata  in  32  write data (data phase).
hready  out  1  transfer done / bus ready.
hresp  out  2  00 OKAY, 01 ERROR.
hrdata  out  32  read data.
sram_csn  out  1  chip select, active low.
sram_wen  out  1  write enable, active low.
sram_be  out  4  byte-lane write enables, active high, bit i = hwdata[8i+7:8i].
sram_a  out  SRAM_AW  word address.
sram_d  out  32  write data = hwdata.
sram_q  in  32  read data, valid the cycle after a read strobe; holds until the next access.

Behaviour:
- Reset is synchronous on hclk when hresetn=0. Reset values:
  - state IDLE
  - hready=1, hresp=OKAY, hrdata=0
  - sram_csn=1, sram_wen=1, sram_be=0, sram_a=0
  - wait counter 0
- Address phase is accepted when hready=1 && hsel=1 && htrans[1]=1. The controller registers addr, hwrite and hsize.
- IDLE/BUSY transfers, and any transfer with hsel=0, cause no SRAM access. The following data phase is OKAY with zero wait.
- Error check runs on the accepted address phase. A transfer is an error if any of these hold:
  - hsize > 3'b010
  - hsize=halfword with haddr[0]=1
  - hsize=word with haddr[1:0]!=0
  - haddr[31:SRAM_AW+2] != 0
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RD_DONE, ERR1, ERR2.
- Next state is taken from the accepted address phase:
  - error -> ERR1
  - write -> WR
  - read -> RD_ISSUE
  - no accept -> IDLE
- Accepting states (hready=1) are IDLE, WR, RD_DONE and ERR2. Next state in any of these is chosen by the rule above.
- WR (1 cycle, zero wait):
  - sram_csn=0, sram_wen=0, sram_a=reg_addr[SRAM_AW+1:2]
  - sram_be: byte 1<<addr[1:0]; halfword 0011 (addr[1]=0) or 1100; word 1111 (little-endian)
  - hready=1, hresp=OKAY
- RD_ISSUE: sram_csn=0, sram_wen=1, sram_be=0, hready=0. Goes to RD_WAIT if WAIT_STATES>0, else to RD_DONE.
- RD_WAIT: sram_csn=1, hready=0. Counter runs WAIT_STATES cycles, then goes to RD_DONE.
- RD_DONE: hready=1, hresp=OKAY, hrdata=sram_q.
- Read latency: hready is low for 1+WAIT_STATES cycles.
- ERR1: hready=0, hresp=ERROR. ERR2: hready=1, hresp=ERROR. Neither state accesses the SRAM (csn=1).
- hrdata=0 in every state except RD_DONE.
- Back-to-back write then read: the write performs in WR while the read's address phase is accepted. The read issues in the next cycle, so there is no hazard.
- Address-phase signals are ignored while hready=0, i.e. the master is stalled.
- Reset mid-operation aborts the transfer, goes to IDLE on the next edge with the reset values above, and leaves no SRAM strobe pending.

Test Plan:
- Single word write 0xDEADBEEF @0x10, then read @0x10 with WAIT_STATES=0:
  - write cycle: csn=0, wen=0, a=4, be=1111
  - read: hready low 1 cycle, hrdata=0xDEADBEEF
- Byte write 0xAA @0x13 then halfword 0x5555 @0x14:
  - be=1000 then be=0011
  - word read @0x10 returns 0xAA.. in the top byte, other lanes unchanged
- WAIT_STATES=3, read @0x20:
  - hready low exactly 4 cycles
  - csn low only in the first of those cycles
  - hrdata valid when hready=1
- Error cases: halfword @0x01; word @0x4002 (SRAM_AW=12); hsize=3'b011:
  - each gives hresp=ERROR for 2 cycles, hready 0 then 1
  - csn stays 1
- INCR4 burst of writes @0x40..0x4C, then INCR4 reads:
  - writes complete with zero wait
  - each read data phase has 1+WAIT_STATES waits
  - data matches what was written
  - BUSY inserted mid-burst causes no SRAM access
- hresetn=0 during RD_WAIT:
  - next edge gives hready=1, hresp=OKAY, csn=1
  - a fresh write after reset completes normally
